// File: rtl/parc_core_rob_fill_arbiter_pkg.sv
// Shared ROB fill-path constants and the holding-buffer payload type.
package parc_CoreRobPkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned SLOT_W  = 4;
  localparam int unsigned PREG_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned GID_W   = 2;
  localparam int unsigned CNT_W   = 16;

  // Functional-unit request indices
  localparam int unsigned FU_ALU    = 0;
  localparam int unsigned FU_MULDIV = 1;
  localparam int unsigned FU_MEM    = 2;

  // One completed result waiting for the fill port
  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } fill_entry_t;

endpackage

// File: rtl/parc_core_rob_fill_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first live requester at or after rr_ptr.
module parc_core_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] live,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan NUM_REQ positions starting at rr_ptr, wrapping explicitly at NUM_REQ-1
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && live[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
      idx = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/parc_core_rob_fill_arbiter.sv
// Shares the single ROB fill port among the functional units with one-entry
// holding buffers, squash filtering and round-robin grant.
module parc_core_rob_fill_arbiter
  import parc_CoreRobPkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_val,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ*SLOT_W-1:0] req_slot,
  input  logic [NUM_REQ*PREG_W-1:0] req_preg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      squash_val,
  input  logic [SLOT_W-1:0]         squash_slot,
  output logic                      rob_fill_val,
  output logic [SLOT_W-1:0]         rob_fill_slot,
  output logic                      wb_val,
  output logic [PREG_W-1:0]         wb_preg,
  output logic [DATA_W-1:0]         wb_data,
  output logic [GID_W-1:0]          grant_id,
  output logic [CNT_W-1:0]          conflict_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  fill_entry_t        buf_q [NUM_REQ];
  logic [NUM_REQ-1:0] full_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   conflict_q;

  fill_entry_t        in_ent [NUM_REQ];
  logic [NUM_REQ-1:0] in_kill;
  logic [NUM_REQ-1:0] live;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic [IDX_W-1:0]   winner;
  logic               any_live;
  logic               multi_live;
  fill_entry_t        win_ent;

  // Unpack incoming results and apply the squash filter to buffers and inputs
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      in_ent[i].slot = req_slot[i*SLOT_W +: SLOT_W];
      in_ent[i].preg = req_preg[i*PREG_W +: PREG_W];
      in_ent[i].data = req_data[i*DATA_W +: DATA_W];
      in_kill[i]     = squash_val && (in_ent[i].slot == squash_slot);
      live[i]        = full_q[i] && !(squash_val && (buf_q[i].slot == squash_slot));
    end
  end

  parc_core_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .live   (live),
    .rr_ptr (rr_ptr_q),
    .grant  (grant),
    .winner (winner)
  );

  // Ready is independent of req_val; a granted buffer can be refilled same cycle
  always_comb begin
    req_rdy    = ~full_q | grant;
    accept     = req_val & req_rdy;
    any_live   = |live;
    multi_live = ($countones(live) > 1);
    win_ent    = buf_q[winner];
  end

  // Fill port and writeback bus driven from the winner, zero when idle
  always_comb begin
    rob_fill_val  = any_live;
    wb_val        = any_live;
    rob_fill_slot = any_live ? win_ent.slot : '0;
    wb_preg       = any_live ? win_ent.preg : '0;
    wb_data       = any_live ? win_ent.data : '0;
    grant_id      = any_live ? GID_W'(winner) : '0;
    conflict_cnt  = conflict_q;
  end

  // Holding buffers: load on accept (dropped if squashed), clear on grant or squash
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          full_q[i] <= !in_kill[i];
          buf_q[i]  <= in_ent[i];
        end else if (grant[i] || (full_q[i] && !live[i])) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances past the winner, holds when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (any_live) begin
      rr_ptr_q <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

  // Saturating count of cycles where more than one buffer competes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_q <= '0;
    end else if (multi_live && (conflict_q != '1)) begin
      conflict_q <= conflict_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parc_core_rob_fill_arbiter.sv
// Bench for the ROB fill arbiter: directed table, corner sequences, random vs model.
module tb_parc_core_rob_fill_arbiter;
  import parc_CoreRobPkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_val;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [NUM_REQ*SLOT_W-1:0] req_slot;
  logic [NUM_REQ*PREG_W-1:0] req_preg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      squash_val;
  logic [SLOT_W-1:0]         squash_slot;
  logic                      rob_fill_val;
  logic [SLOT_W-1:0]         rob_fill_slot;
  logic                      wb_val;
  logic [PREG_W-1:0]         wb_preg;
  logic [DATA_W-1:0]         wb_data;
  logic [GID_W-1:0]          grant_id;
  logic [CNT_W-1:0]          conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  parc_core_rob_fill_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_val       (req_val),
    .req_rdy       (req_rdy),
    .req_slot      (req_slot),
    .req_preg      (req_preg),
    .req_data      (req_data),
    .squash_val    (squash_val),
    .squash_slot   (squash_slot),
    .rob_fill_val  (rob_fill_val),
    .rob_fill_slot (rob_fill_slot),
    .wb_val        (wb_val),
    .wb_preg       (wb_preg),
    .wb_data       (wb_data),
    .grant_id      (grant_id),
    .conflict_cnt  (conflict_cnt)
  );

  // Reference model: per-unit pending result, pointer, counter
  bit          m_full [NUM_REQ];
  logic [3:0]  m_slot [NUM_REQ];
  logic [4:0]  m_preg [NUM_REQ];
  logic [31:0] m_data [NUM_REQ];
  int          m_ptr;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_full[i] = 0; m_slot[i] = '0; m_preg[i] = '0; m_data[i] = '0;
    end
    m_ptr = 0;
    m_cnt = 0;
  endtask

  // Compare DUT outputs with the model's view of this cycle, then advance the model
  task automatic model_cycle();
    bit   live [NUM_REQ];
    int   win;
    int   nlive;
    logic [2:0] e_rdy;
    win = -1;
    nlive = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      live[i] = m_full[i] && !(squash_val && m_slot[i] == squash_slot);
      if (live[i]) nlive++;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NUM_REQ;
      if (win < 0 && live[idx]) win = idx;
    end
    for (int i = 0; i < NUM_REQ; i++) e_rdy[i] = !m_full[i] || (i == win);
    chk("model_rdy",  32'(req_rdy), 32'(e_rdy));
    chk("model_fill", 32'(rob_fill_val), (win >= 0) ? 32'd1 : 32'd0);
    chk("model_wbv",  32'(wb_val), (win >= 0) ? 32'd1 : 32'd0);
    chk("model_slot", 32'(rob_fill_slot), (win >= 0) ? 32'(m_slot[win]) : 32'd0);
    chk("model_preg", 32'(wb_preg), (win >= 0) ? 32'(m_preg[win]) : 32'd0);
    chk("model_data", wb_data, (win >= 0) ? m_data[win] : 32'd0);
    chk("model_gid",  32'(grant_id), (win >= 0) ? 32'(win) : 32'd0);
    chk("model_cnt",  32'(conflict_cnt), 32'(m_cnt));
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [3:0] s;
      s = req_slot[i*SLOT_W +: SLOT_W];
      if (req_val[i] && e_rdy[i]) begin
        m_full[i] = !(squash_val && s == squash_slot);
        m_slot[i] = s;
        m_preg[i] = req_preg[i*PREG_W +: PREG_W];
        m_data[i] = req_data[i*DATA_W +: DATA_W];
      end else if (i == win || !live[i]) begin
        m_full[i] = 0;
      end
    end
    if (win >= 0) m_ptr = (win + 1) % NUM_REQ;
    if (nlive > 1 && m_cnt < 65535) m_cnt++;
  endtask

  // Drive one cycle of inputs; preg/data derive from the slot so fills are traceable
  task automatic drive(input logic [2:0] v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic sq, input logic [3:0] sqs);
    logic [3:0] s [3];
    s[0] = s0; s[1] = s1; s[2] = s2;
    req_val = v;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_slot[i*SLOT_W +: SLOT_W] = s[i];
      req_preg[i*PREG_W +: PREG_W] = 5'(s[i]) + 5'd4;
      req_data[i*DATA_W +: DATA_W] = 32'h0000_DEAA + 32'(s[i]);
    end
    squash_val  = sq;
    squash_slot = sqs;
  endtask

  task automatic finish_cycle();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  val;
    logic [3:0]  s0, s1, s2;
    logic        sq;
    logic [3:0]  sqs;
    logic        e_fill;
    logic [3:0]  e_slot;
    logic [1:0]  e_gid;
    logic [2:0]  e_rdy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [20];

  initial begin
    // A-C single ALU result; D-E move pointer to 0; F-I full contention from 0
    tbl[0]  = '{3'b001, 4'd3, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd0};
    tbl[1]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 2'd0, 3'b111, 16'd0};
    tbl[2]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd0};
    tbl[3]  = '{3'b100, 4'd0, 4'd0, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd0};
    tbl[4]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd9, 2'd2, 3'b111, 16'd0};
    tbl[5]  = '{3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd0};
    tbl[6]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1, 2'd0, 3'b001, 16'd0};
    tbl[7]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 2'd1, 3'b011, 16'd1};
    tbl[8]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 2'd2, 3'b111, 16'd2};
    // J-K move pointer to 2; L-O contention wrapping MEM, ALU, MULDIV
    tbl[9]  = '{3'b010, 4'd0, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd2};
    tbl[10] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd6, 2'd1, 3'b111, 16'd2};
    tbl[11] = '{3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd2};
    tbl[12] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 2'd2, 3'b100, 16'd2};
    tbl[13] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1, 2'd0, 3'b101, 16'd3};
    tbl[14] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 2'd1, 3'b111, 16'd4};
    // P-R squash of buffered MULDIV slot 5 while ALU wins; S-T squashed incoming request
    tbl[15] = '{3'b011, 4'd4, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd4};
    tbl[16] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 1'b1, 4'd4, 2'd0, 3'b101, 16'd4};
    tbl[17] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd4};
    tbl[18] = '{3'b001, 4'd8, 4'd0, 4'd0, 1'b1, 4'd8, 1'b0, 4'd0, 2'd0, 3'b111, 16'd4};
    tbl[19] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 3'b111, 16'd4};

    reset = 1'b1;
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_rdy",  32'(req_rdy), 32'h7);
      chk("idle_fill", 32'(rob_fill_val), 32'd0);
      chk("idle_cnt",  32'(conflict_cnt), 32'd0);
      finish_cycle();
    end

    // Directed table
    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].val, tbl[r].s0, tbl[r].s1, tbl[r].s2, tbl[r].sq, tbl[r].sqs);
      @(negedge clk);
      chk($sformatf("tbl%0d_fill", r), 32'(rob_fill_val), 32'(tbl[r].e_fill));
      chk($sformatf("tbl%0d_slot", r), 32'(rob_fill_slot), tbl[r].e_fill ? 32'(tbl[r].e_slot) : 32'd0);
      chk($sformatf("tbl%0d_preg", r), 32'(wb_preg), tbl[r].e_fill ? 32'(tbl[r].e_slot) + 32'd4 : 32'd0);
      chk($sformatf("tbl%0d_data", r), wb_data, tbl[r].e_fill ? 32'h0000_DEAA + 32'(tbl[r].e_slot) : 32'd0);
      chk($sformatf("tbl%0d_gid", r),  32'(grant_id), 32'(tbl[r].e_gid));
      chk($sformatf("tbl%0d_rdy", r),  32'(req_rdy), 32'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_cnt", r),  32'(conflict_cnt), 32'(tbl[r].e_cnt));
      finish_cycle();
    end

    // ALU streams slots 0..15 back to back
    for (int k = 0; k < 16; k++) begin
      drive(3'b001, 4'(k), 4'd0, 4'd0, 1'b0, 4'd0);
      @(negedge clk);
      chk("stream_rdy0", 32'(req_rdy[0]), 32'd1);
      chk("stream_fill", 32'(rob_fill_val), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) chk("stream_slot", 32'(rob_fill_slot), 32'(k - 1));
      finish_cycle();
    end
    drive(3'b100, 4'd0, 4'd0, 4'd12, 1'b0, 4'd0);
    @(negedge clk);
    chk("stream_last", 32'(rob_fill_slot), 32'd15);
    finish_cycle();

    // Reset with MEM buffered: outputs drop in the same cycle
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
    #1;
    chk("pre_rst_fill", 32'(rob_fill_slot), 32'd12);
    reset = 1'b1;
    #1;
    chk("rst_fill", 32'(rob_fill_val), 32'd0);
    chk("rst_wbv",  32'(wb_val), 32'd0);
    chk("rst_slot", 32'(rob_fill_slot), 32'd0);
    chk("rst_preg", 32'(wb_preg), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_gid",  32'(grant_id), 32'd0);
    chk("rst_rdy",  32'(req_rdy), 32'h7);
    chk("rst_cnt",  32'(conflict_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_fill", 32'(rob_fill_val), 32'd0);
    finish_cycle();

    // Random traffic against the model
    for (int c = 0; c < 500; c++) begin
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
            4'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 5)));
      for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
      @(negedge clk);
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
